// File: rtl/seg_scan_decoder.sv
// Recovers the hex digit shown on each position of a multiplexed active-low 7-segment bus.
// Build option: define SEG_SCAN_BLANK_DETECT_EN to accept the all-off pattern as a legal blank.
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update_pulse,
   output logic                    frame_pulse,
   output logic                    err_pulse,
   output logic [ERR_CNT_W-1:0]    err_count
);

   localparam int SW    = 7 + NUM_DIGITS;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

   logic [SW-1:0]           sync1, sync2, prev;
   logic [CNT_W-1:0]        stable_cnt;
   logic                    accepted;
   logic [NUM_DIGITS-1:0]   frame_mask;

   logic                    same, accept, onehot, dec_hit, mark;
   logic [3:0]              dec_val;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [4*NUM_DIGITS-1:0] digits_n;
   logic [NUM_DIGITS-1:0]   valid_n, mask_n;
   logic                    upd_n, frm_n, err_n;
   logic [ERR_CNT_W-1:0]    cnt_n;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40: decode = {1'b1, 4'h0};
         7'h79: decode = {1'b1, 4'h1};
         7'h24: decode = {1'b1, 4'h2};
         7'h30: decode = {1'b1, 4'h3};
         7'h19: decode = {1'b1, 4'h4};
         7'h12: decode = {1'b1, 4'h5};
         7'h02: decode = {1'b1, 4'h6};
         7'h78: decode = {1'b1, 4'h7};
         7'h00: decode = {1'b1, 4'h8};
         7'h10: decode = {1'b1, 4'h9};
         7'h08: decode = {1'b1, 4'hA};
         7'h03: decode = {1'b1, 4'hB};
         7'h46: decode = {1'b1, 4'hC};
         7'h21: decode = {1'b1, 4'hD};
         7'h06: decode = {1'b1, 4'hE};
         7'h0E: decode = {1'b1, 4'hF};
         default: decode = 5'b0_0000;
      endcase
   endfunction

   assign seg     = sync2[6:0];
   assign an_sel  = ~sync2[SW-1:7];
   assign onehot  = (an_sel != '0) && ((an_sel & (an_sel - NUM_DIGITS'(1))) == '0);
   assign {dec_hit, dec_val} = decode(seg);
   assign same    = (sync2 == prev);
   // Accept on the same edge the counter reaches its terminal value, so the
   // output register lands STABLE_CYCLES+2 edges after the pins settle.
   assign accept  = same && (stable_cnt >= CNT_PRE) && !accepted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= '1;
         sync2      <= '1;
         prev       <= '1;
         stable_cnt <= '0;
         accepted   <= 1'b0;
      end else begin
         sync1 <= {an_in, seg_in};
         sync2 <= sync1;
         prev  <= sync2;
         if (!same) begin
            stable_cnt <= '0;
            accepted   <= 1'b0;
         end else begin
            if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_W'(1);
            if (accept) accepted <= 1'b1;
         end
      end
   end

   always_comb begin
      digits_n = digits_out;
      valid_n  = digit_valid;
      mask_n   = frame_mask;
      cnt_n    = err_count;
      upd_n    = 1'b0;
      frm_n    = 1'b0;
      err_n    = 1'b0;
      mark     = 1'b0;
      if (accept && onehot) begin
         if (dec_hit) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
               if (an_sel[i]) digits_n[4*i +: 4] = dec_val;
            valid_n = digit_valid | an_sel;
            upd_n   = 1'b1;
            mark    = 1'b1;
         end
`ifdef SEG_SCAN_BLANK_DETECT_EN
         else if (seg == 7'h7F) begin
            valid_n = digit_valid & ~an_sel;
            upd_n   = 1'b1;
            mark    = 1'b1;
         end
`endif
         else begin
            err_n = 1'b1;
            if (err_count != '1) cnt_n = err_count + ERR_CNT_W'(1);
         end
         if (mark) begin
            mask_n = frame_mask | an_sel;
            if (mask_n == '1) begin
               frm_n  = 1'b1;
               mask_n = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_out   <= '0;
         digit_valid  <= '0;
         frame_mask   <= '0;
         err_count    <= '0;
         update_pulse <= 1'b0;
         frame_pulse  <= 1'b0;
         err_pulse    <= 1'b0;
      end else begin
         digits_out   <= digits_n;
         digit_valid  <= valid_n;
         frame_mask   <= mask_n;
         err_count    <= cnt_n;
         update_pulse <= upd_n;
         frame_pulse  <= frm_n;
         err_pulse    <= err_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random bus traffic
// compared against a pin-level run-length reference model.
module tb_seg_scan_decoder;
   localparam int N  = 4;
   localparam int S  = 4;
   localparam int EW = 8;
`ifdef SEG_SCAN_BLANK_DETECT_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [6:0]     seg_in = 7'h7F;
   logic [N-1:0]   an_in = '1;
   logic [4*N-1:0] digits_out;
   logic [N-1:0]   digit_valid;
   logic           update_pulse, frame_pulse, err_pulse;
   logic [EW-1:0]  err_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .ERR_CNT_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
      .digits_out(digits_out), .digit_valid(digit_valid),
      .update_pulse(update_pulse), .frame_pulse(frame_pulse),
      .err_pulse(err_pulse), .err_count(err_count)
   );

   logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: a pattern counts once it has sat on the pins for S
   // consecutive edges; its effect appears two edges later.
   logic [4*N-1:0] m_digits;
   logic [N-1:0]   m_valid, m_mask, h_an, d0_an, d1_an;
   logic           m_upd, m_frm, m_err, d0_v, d1_v, m_mark;
   logic [EW-1:0]  m_cnt;
   logic [6:0]     h_seg, d0_seg, d1_seg;
   int             run, m_di, m_v;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_digits = '0; m_valid = '0; m_mask = '0; m_cnt = '0;
         m_upd = 0; m_frm = 0; m_err = 0;
         h_seg = '1; h_an = '1; run = S + 1;
         d0_v = 0; d1_v = 0; d0_seg = '1; d1_seg = '1; d0_an = '1; d1_an = '1;
      end else begin
         m_upd = 0; m_frm = 0; m_err = 0; m_mark = 0;
         if (d1_v && $countones(~d1_an) == 1) begin
            m_di = 0;
            for (int i = 0; i < N; i++) if (!d1_an[i]) m_di = i;
            m_v = -1;
            for (int j = 0; j < 16; j++) if (pat[j] == d1_seg) m_v = j;
            if (m_v >= 0) begin
               m_digits[4*m_di +: 4] = 4'(m_v);
               m_valid[m_di] = 1'b1; m_upd = 1; m_mark = 1;
            end else if (BLANK && d1_seg == 7'h7F) begin
               m_valid[m_di] = 1'b0; m_upd = 1; m_mark = 1;
            end else begin
               m_err = 1;
               if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            end
            if (m_mark) begin
               m_mask[m_di] = 1'b1;
               if (&m_mask) begin m_frm = 1; m_mask = '0; end
            end
         end
         d1_v = d0_v; d1_seg = d0_seg; d1_an = d0_an;
         if ({an_in, seg_in} == {h_an, h_seg}) run++;
         else begin run = 1; h_seg = seg_in; h_an = an_in; end
         d0_v = (run == S); d0_seg = h_seg; d0_an = h_an;
      end
   end

   task test_reset;
      rst_n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seg_in = 7'($urandom); an_in = N'($urandom);
      end
      @(negedge clk);
      total++;
      if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count});
      end
      rst_n = 1; an_in = 4'b1110; seg_in = 7'h24;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         total++;
         if (k == 6) begin
            if (digits_out[3:0] !== 4'h2 || digit_valid !== 4'b0001 || update_pulse !== 1'b1) begin
               bad++;
               $display("FAIL reset_first_accept edge=%0d got d=%h v=%b u=%b want d=2 v=0001 u=1",
                        k, digits_out[3:0], digit_valid, update_pulse);
            end
         end else if (update_pulse !== 1'b0 || (k < 6 && digit_valid !== '0)) begin
            bad++;
            $display("FAIL reset_latency edge=%0d got v=%b u=%b", k, digit_valid, update_pulse);
         end
         total++;
         if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !==
             {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt}) begin
            bad++;
            $display("FAIL model_reset t=%0t got=%h want=%h", $time,
                     {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count},
                     {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt});
         end
      end
   endtask

   task test_glitch;
      an_in = 4'b1101; seg_in = 7'h30;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (k == 2) seg_in = 7'h79;
         total++;
         if (digits_out[7:4] === 4'h3) begin
            bad++;
            $display("FAIL glitch_leak cycle=%0d got=%h want not 3", k, digits_out[7:4]);
         end
      end
      total++;
      if (digits_out[7:4] !== 4'h1 || digit_valid[1] !== 1'b1) begin
         bad++;
         $display("FAIL glitch_final got d=%h v=%b want d=1 v=1", digits_out[7:4], digit_valid[1]);
      end
   endtask

   task test_full_scan;
      int upd, frm;
      bit frm_on_4th;
      for (int sc = 0; sc < 2; sc++) begin
         upd = 0; frm = 0; frm_on_4th = 0;
         for (int d = 0; d < N; d++) begin
            an_in = ~(N'(1) << d); seg_in = pat[d+1];
            for (int c = 0; c < 8; c++) begin
               @(negedge clk);
               if (update_pulse === 1'b1) upd++;
               if (frame_pulse === 1'b1) begin
                  frm++;
                  if (update_pulse === 1'b1 && upd == 4) frm_on_4th = 1;
               end
               total++;
               if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !==
                   {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt}) begin
                  bad++;
                  $display("FAIL model_scan t=%0t got=%h want=%h", $time,
                           {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count},
                           {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt});
               end
            end
         end
         total++;
         if (digits_out !== 16'h4321 || upd != 4 || frm != 1 || !frm_on_4th) begin
            bad++;
            $display("FAIL scan_%0d got d=%h upd=%0d frm=%0d on4th=%0d want d=4321 upd=4 frm=1 on4th=1",
                     sc, digits_out, upd, frm, frm_on_4th);
         end
      end
   endtask

   task test_error;
      int errs;
      errs = 0;
      an_in = 4'b1011; seg_in = 7'h55;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (err_pulse === 1'b1) errs++;
      end
      total++;
      if (errs != 1 || err_count !== 8'd1 || digits_out[11:8] !== 4'h3 || digit_valid[2] !== 1'b1) begin
         bad++;
         $display("FAIL error_single got errs=%0d cnt=%0d d=%h v=%b want errs=1 cnt=1 d=3 v=1",
                  errs, err_count, digits_out[11:8], digit_valid[2]);
      end
      for (int r = 0; r < 300; r++) begin
         seg_in = (r % 2 == 0) ? 7'h56 : 7'h55;
         repeat ($urandom_range(4, 8)) begin
            @(negedge clk);
            total++;
            if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !==
                {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt}) begin
               bad++;
               $display("FAIL model_error t=%0t got=%h want=%h", $time,
                        {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count},
                        {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt});
            end
         end
      end
      repeat (4) @(negedge clk);
      total++;
      if (err_count !== 8'd255) begin
         bad++;
         $display("FAIL error_saturate got=%0d want=255", err_count);
      end
   endtask

   task test_blank_bad_an;
      int upd, errs;
      upd = 0; errs = 0;
      an_in = 4'b1110; seg_in = 7'h7F;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (update_pulse === 1'b1) upd++;
         if (err_pulse === 1'b1) errs++;
      end
      total++;
      if (BLANK ? (upd != 1 || errs != 0 || digit_valid[0] !== 1'b0 || digits_out[3:0] !== 4'h1)
                : (upd != 0 || errs != 1 || digit_valid[0] !== 1'b1 || digits_out[3:0] !== 4'h1)) begin
         bad++;
         $display("FAIL blank got upd=%0d errs=%0d v0=%b d0=%h blank_en=%0d",
                  upd, errs, digit_valid[0], digits_out[3:0], BLANK);
      end
      upd = 0; errs = 0;
      for (int p = 0; p < 2; p++) begin
         an_in = (p == 0) ? 4'b1100 : 4'b1111; seg_in = 7'h40;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (update_pulse === 1'b1) upd++;
            if (err_pulse === 1'b1) errs++;
         end
      end
      total++;
      if (upd != 0 || errs != 0) begin
         bad++;
         $display("FAIL bad_anodes got upd=%0d errs=%0d want 0 0", upd, errs);
      end
   endtask

   task test_random;
      for (int r = 0; r < 250; r++) begin
         seg_in = ($urandom_range(0, 3) != 0) ? pat[$urandom_range(0, 15)] : 7'($urandom);
         an_in  = ($urandom_range(0, 3) != 0) ? ~(N'(1) << $urandom_range(0, N-1)) : N'($urandom);
         repeat ($urandom_range(1, 8)) begin
            @(negedge clk);
            total++;
            if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !==
                {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt}) begin
               bad++;
               $display("FAIL model_random t=%0t got=%h want=%h", $time,
                        {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count},
                        {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt});
            end
         end
      end
   endtask

   task test_async_reset;
      for (int d = 0; d < 3; d++) begin
         an_in = ~(N'(1) << d); seg_in = pat[d+5];
         repeat ((d == 2) ? 3 : 8) @(negedge clk);
      end
      #2 rst_n = 0;
      #1;
      total++;
      if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !== '0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0",
                  {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count});
      end
      @(negedge clk);
      rst_n = 1; an_in = 4'b1110; seg_in = 7'h12;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         total++;
         if ((k == 6) ? (update_pulse !== 1'b1 || digits_out[3:0] !== 4'h5 || digit_valid !== 4'b0001)
                      : (update_pulse !== 1'b0)) begin
            bad++;
            $display("FAIL async_resume edge=%0d got u=%b d=%h v=%b want u=%0d", k,
                     update_pulse, digits_out[3:0], digit_valid, (k == 6));
         end
         total++;
         if ({digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count} !==
             {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt}) begin
            bad++;
            $display("FAIL model_async t=%0t got=%h want=%h", $time,
                     {digits_out, digit_valid, update_pulse, frame_pulse, err_pulse, err_count},
                     {m_digits, m_valid, m_upd, m_frm, m_err, m_cnt});
         end
      end
   endtask

   initial begin
      test_reset;
      test_glitch;
      test_full_scan;
      test_error;
      test_blank_bad_an;
      test_random;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
